// File: rtl/bitonic_seq_ctrl.sv
// Pass scheduler for a shared bitonic compare-exchange network, one (stage, step) column per pass.
// Define BITONIC_SEQ_TIMEOUT_EN to add a WAIT-state watchdog that pulses err and drops the vector.
module bitonic_seq_ctrl #(
    parameter int    DATA_WIDTH  = 64,
    parameter int    DATA_CNT    = 8,
    parameter string COM_STYLE   = "UP",
    parameter int    TIMEOUT_CYC = 256,
    localparam int   L           = $clog2(DATA_CNT),
    localparam int   IW          = (L > 1) ? $clog2(L) : 1,
    localparam int   VW          = DATA_CNT * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [VW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] out_data,
    output logic          net_start,
    output logic [IW-1:0] net_stage,
    output logic [IW-1:0] net_step,
    output logic          net_desc,
    output logic [VW-1:0] net_data_o,
    input  logic [VW-1:0] net_data_i,
    input  logic          net_done,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] LAST_S   = IW'(L - 1);
    localparam bit            DESC     = (COM_STYLE == "DOWN");

    state_e          state_q, state_d;
    logic [IW-1:0]   s_q, s_d;
    logic [IW-1:0]   t_q, t_d;
    logic [VW-1:0]   work_q, work_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            net_start_q;
    logic            busy_q;

`ifdef BITONIC_SEQ_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Index walk: t counts down to 0 inside a stage, then the next stage restarts at t = s+1.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        t_d     = t_q;
        work_d  = work_q;
`ifdef BITONIC_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_data;
                    s_d     = IDX_ZERO;
                    t_d     = IDX_ZERO;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef BITONIC_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (net_done) begin
                    work_d = net_data_i;
                    if (t_q != IDX_ZERO) begin
                        t_d     = t_q - IDX_ONE;
                        state_d = ISSUE;
                    end else if (s_q != LAST_S) begin
                        s_d     = s_q + IDX_ONE;
                        t_d     = s_q + IDX_ONE;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
`ifdef BITONIC_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    work_d  = '0;
                    s_d     = IDX_ZERO;
                    t_d     = IDX_ZERO;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    s_d     = IDX_ZERO;
                    t_d     = IDX_ZERO;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and launch flags are derived from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= IDX_ZERO;
            t_q         <= IDX_ZERO;
            work_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            net_start_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BITONIC_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            t_q         <= t_d;
            work_q      <= work_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            net_start_q <= (state_d == ISSUE);
            busy_q      <= (state_d != IDLE);
`ifdef BITONIC_SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = work_q;
    assign net_start  = net_start_q;
    assign net_stage  = s_q;
    assign net_step   = t_q;
    assign net_desc   = DESC;
    assign net_data_o = work_q;
    assign busy       = busy_q;

`ifdef BITONIC_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bitonic_seq_ctrl.sv
// Directed bench for bitonic_seq_ctrl with a behavioural compare-exchange network of programmable latency.
// The watchdog scenario is only exercised when BITONIC_SEQ_TIMEOUT_EN is defined.
module tb_bitonic_seq_ctrl;

    typedef struct packed {
        logic [63:0] inVec;
        logic [63:0] expVec;
        logic [7:0]  lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        net_start;
    logic [1:0]  net_stage;
    logic [1:0]  net_step;
    logic        net_desc;
    logic [63:0] net_data_o;
    logic [63:0] net_data_i;
    logic        net_done;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    int          netLat     = 2;
    bit          modelMute  = 1'b0;
    bit          idleSpur   = 1'b0;
    int          spurTarget = -1;
    int          modelCnt   = 0;
    bit          modelDone  = 1'b0;
    bit          spurOn     = 1'b0;
    logic [63:0] modelData  = '0;
    logic [63:0] passData   = '0;
    int          passStage  = 0;
    int          passStep   = 0;
    int          startCount = 0;
    logic [3:0]  stageLog[256];
    logic [3:0]  stepLog[256];

    vec_t vecs[4];

    bitonic_seq_ctrl #(
        .DATA_WIDTH (8),
        .DATA_CNT   (8),
        .COM_STYLE  ("UP"),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .net_start (net_start),
        .net_stage (net_stage),
        .net_step  (net_step),
        .net_desc  (net_desc),
        .net_data_o(net_data_o),
        .net_data_i(net_data_i),
        .net_done  (net_done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign net_done   = modelDone | spurOn | idleSpur;
    assign net_data_i = (spurOn | idleSpur) ? 64'hA5A5_A5A5_A5A5_A5A5 : modelData;

    // One column of compare-exchanges: partner i^2^t, direction flips on bit s+1 of the index.
    function automatic logic [63:0] netPass(input logic [63:0] v, input int s, input int t, input bit desc);
        logic [63:0] r;
        r = v;
        for (int i = 0; i < 8; i++) begin
            int j;
            j = i ^ (1 << t);
            if (j > i) begin
                logic [7:0] a;
                logic [7:0] b;
                bit         up;
                a  = v[i*8 +: 8];
                b  = v[j*8 +: 8];
                up = (((i >> (s + 1)) & 1) == 0);
                if (desc) up = !up;
                if (up ? (a > b) : (a < b)) begin
                    r[i*8 +: 8] = b;
                    r[j*8 +: 8] = a;
                end
            end
        end
        return r;
    endfunction

    // Network model: answers netLat cycles after the launch cycle, logging each launch.
    always @(negedge clk) begin
        modelDone = 1'b0;
        spurOn    = 1'b0;
        if (rst) begin
            modelCnt = 0;
        end else begin
            if (modelCnt > 0) begin
                modelCnt = modelCnt - 1;
                if (modelCnt == 0 && !modelMute) begin
                    modelDone = 1'b1;
                    modelData = netPass(passData, passStage, passStep, net_desc);
                end
            end
            if (net_start) begin
                modelCnt   = netLat;
                passData   = net_data_o;
                passStage  = int'(net_stage);
                passStep   = int'(net_step);
                stageLog[startCount % 256] = 4'(net_stage);
                stepLog[startCount % 256]  = 4'(net_step);
                startCount = startCount + 1;
                if (startCount == spurTarget) spurOn = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Full sort: handshake in, track latency and launches, optionally stall the consumer, drain.
    task automatic applyStimulus(input logic [63:0] vec, input int lat, input int hold,
                                 output logic [63:0] res, output int lag);
        int          guard;
        int          base;
        int          holdBad;
        logic [63:0] held;
        logic [63:0] gotSeq;
        logic [63:0] wantSeq;
        wantSeq = 64'h0000_2021_2210_1100;
        @(negedge clk);
        netLat   = lat;
        base     = startCount;
        in_data  = vec;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptWait", 64'(guard < 50), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput("inFlightFlags", {62'd0, in_ready, busy}, 64'd1);
        lag = 1;
        while (!out_valid && lag < 300) begin
            @(negedge clk);
            lag++;
        end
        checkOutput("outValidRise", 64'(out_valid), 64'd1);
        checkOutput("latency", 64'(lag), 64'(1 + 6 * (1 + lat)));
        checkOutput("startCount", 64'(startCount - base), 64'd6);
        gotSeq = '0;
        for (int k = 0; k < 6; k++) begin
            gotSeq[k*8 +: 8] = {stageLog[(base + k) % 256], stepLog[(base + k) % 256]};
        end
        checkOutput("passSeq", gotSeq, wantSeq);
        held    = out_data;
        holdBad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || out_data !== held || in_ready) holdBad++;
        end
        if (hold > 0) checkOutput("holdStable", 64'(holdBad), 64'd0);
        res       = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("drainFlags", {61'd0, out_valid, in_ready, busy}, 64'd2);
    endtask

    initial begin
        logic [63:0] res;
        int          lag;
        int          k;
        int          guard;
        int          sawValid;
        int          base;

        vecs[0] = '{inVec: 64'h0204_0006_0105_0307, expVec: 64'h0706_0504_0302_0100, lat: 8'd2};
        vecs[1] = '{inVec: 64'h8102_FE7F_0180_00FF, expVec: 64'hFFFE_8180_7F02_0100, lat: 8'd1};
        vecs[2] = '{inVec: 64'h0109_0109_0303_0505, expVec: 64'h0909_0505_0303_0101, lat: 8'd3};
        vecs[3] = '{inVec: 64'h0102_0304_0506_0708, expVec: 64'h0807_0605_0403_0201, lat: 8'd2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("resetCtl", {55'd0, in_ready, out_valid, net_start, busy, err, net_stage, net_step}, 64'd0);
            checkOutput("resetData", net_data_o | out_data, 64'd0);
        end
        checkOutput("netDesc", 64'(net_desc), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", {62'd0, in_ready, busy}, 64'd2);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].inVec, int'(vecs[i].lat), 0, res, lag);
            checkOutput("sortResult", res, vecs[i].expVec);
        end

        $display("[TB] backpressure");
        applyStimulus(vecs[1].inVec, 2, 10, res, lag);
        checkOutput("bpResult", res, vecs[1].expVec);

        $display("[TB] spurious done in IDLE");
        base = startCount;
        @(negedge clk);
        idleSpur = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idleSpur = 1'b0;
        @(negedge clk);
        checkOutput("idleSpurData", net_data_o, vecs[1].expVec);
        checkOutput("idleSpurFlags", {61'd0, in_ready, busy, out_valid}, 64'd4);
        checkOutput("idleSpurStarts", 64'(startCount - base), 64'd0);

        $display("[TB] spurious done in ISSUE");
        spurTarget = startCount + 2;
        applyStimulus(vecs[2].inVec, 2, 0, res, lag);
        spurTarget = -1;
        checkOutput("issueSpurResult", res, vecs[2].expVec);

        $display("[TB] reset during third pass");
        @(negedge clk);
        netLat   = 2;
        in_data  = vecs[0].inVec;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        k        = net_start ? 1 : 0;
        guard    = 0;
        while (k < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (net_start) k++;
        end
        checkOutput("thirdPassSeen", 64'(k), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midResetCtl", {55'd0, in_ready, out_valid, net_start, busy, err, net_stage, net_step}, 64'd0);
        checkOutput("midResetData", net_data_o | out_data, 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        sawValid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) sawValid++;
        end
        checkOutput("noValidAfterReset", 64'(sawValid), 64'd0);
        applyStimulus(vecs[0].inVec, 2, 0, res, lag);
        checkOutput("postResetResult", res, vecs[0].expVec);

`ifdef BITONIC_SEQ_TIMEOUT_EN
        $display("[TB] watchdog");
        modelMute = 1'b1;
        @(negedge clk);
        in_data  = vecs[3].inVec;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        k        = 0;
        while (!err && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("errTiming", 64'(k), 64'd17);
        @(negedge clk);
        checkOutput("errAfter", {61'd0, err, busy, in_ready}, 64'd1);
        checkOutput("errDropped", net_data_o, 64'd0);
        modelMute = 1'b0;
`else
        checkOutput("errTiedLow", 64'(err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
